// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter between NREQ
// byte-level requesters. It drives the transmitter's sel/set/din/baud
// inputs, follows its tx_en busy flag one frame at a time, and reports
// each frame's outcome to its owner as an ack pulse or an err pulse.
// Every output comes straight from a register.
module uart_tx_arbiter #(
   parameter int NREQ     = 4,
   parameter int START_TO = 16,
   parameter int BAUD_W   = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_data,
   input  logic [BAUD_W-1:0]   baud_cfg,
   output logic [NREQ-1:0]     ack,
   output logic [NREQ-1:0]     err,
   output logic [NREQ-1:0]     gnt,
   output logic                busy,
   output logic                tx_sel,
   output logic                tx_set,
   output logic [7:0]          tx_din,
   output logic [BAUD_W-1:0]   tx_baud,
   input  logic                tx_en
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(START_TO) + 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TO - 1);
   localparam logic [NREQ-1:0]  ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_BUSY  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;      // last owner, lowest priority next round
   logic [IDX_W-1:0]  own_q, own_d;      // index of the current owner
   logic [CNT_W-1:0]  cnt_q, cnt_d;      // start-timeout counter
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [NREQ-1:0]   err_q, err_d;
   logic              busy_q, busy_d;
   logic              tx_sel_q, tx_sel_d;
   logic              tx_set_q, tx_set_d;
   logic [7:0]        tx_din_q, tx_din_d;
   logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;

   logic              win_found;
   logic [IDX_W-1:0]  win_idx;

   // Winner search: first requesting index after the pointer, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!win_found && req[(int'(ptr_q) + k) % NREQ]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   // FSM next state together with the next value of every output register.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch to hold it.
      state_d   = state_q;
      ptr_d     = ptr_q;
      own_d     = own_q;
      cnt_d     = cnt_q;
      gnt_d     = gnt_q;
      ack_d     = '0;
      err_d     = '0;
      tx_sel_d  = tx_sel_q;
      tx_set_d  = 1'b0;
      tx_din_d  = tx_din_q;
      tx_baud_d = tx_baud_q;

      case (state_q)
         S_IDLE: begin
            // A transmitter still busy from elsewhere blocks arbitration.
            if (win_found && !tx_en) begin
               own_d     = win_idx;
               gnt_d     = ONE_HOT0 << win_idx;
               tx_din_d  = req_data[{win_idx, 3'b000} +: 8];
               tx_baud_d = baud_cfg;
               tx_sel_d  = 1'b1;
               tx_set_d  = 1'b1;
               cnt_d     = '0;
               state_d   = S_GRANT;
            end
         end
         S_GRANT: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A start seen on the limit cycle still counts as started.
            if (tx_en) begin
               state_d = S_BUSY;
            end else if (cnt_q == CNT_LIMIT) begin
               err_d    = gnt_q;
               ptr_d    = own_q;
               gnt_d    = '0;
               tx_sel_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_BUSY: begin
            if (!tx_en) begin
               ack_d    = gnt_q;
               ptr_d    = own_q;
               tx_sel_d = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d    = '0;
            tx_sel_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= IDX_W'(NREQ - 1);
         own_q     <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         ack_q     <= '0;
         err_q     <= '0;
         busy_q    <= 1'b0;
         tx_sel_q  <= 1'b0;
         tx_set_q  <= 1'b0;
         tx_din_q  <= '0;
         tx_baud_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values;
         // blocking here would let later lines see already-updated state.
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         own_q     <= own_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         tx_sel_q  <= tx_sel_d;
         tx_set_q  <= tx_set_d;
         tx_din_q  <= tx_din_d;
         tx_baud_q <= tx_baud_d;
      end
   end

   assign ack     = ack_q;
   assign err     = err_q;
   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign tx_sel  = tx_sel_q;
   assign tx_set  = tx_set_q;
   assign tx_din  = tx_din_q;
   assign tx_baud = tx_baud_q;

endmodule
